// File: rtl/seq_detect_pkg.sv
// Shared definitions for the 1011 sequence detectors.
// Contents:
//   state_t     - 3-bit detector state (IDLE .. SEQ_1011)
//   next_state  - pure next-state function, shared with the single-channel detector
package seq_detect_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEQ_1    = 3'd1,
        SEQ_10   = 3'd2,
        SEQ_101  = 3'd3,
        SEQ_1011 = 3'd4
    } state_t;

    // Overlapping 1011 recogniser; unused encodings fall back to IDLE.
    function automatic state_t next_state(input state_t cur, input logic bit_in);
        state_t nxt;
        case (cur)
            IDLE:     nxt = bit_in ? SEQ_1    : IDLE;
            SEQ_1:    nxt = bit_in ? SEQ_1    : SEQ_10;
            SEQ_10:   nxt = bit_in ? SEQ_101  : IDLE;
            SEQ_101:  nxt = bit_in ? SEQ_1011 : SEQ_10;
            SEQ_1011: nxt = bit_in ? SEQ_1    : SEQ_10;
            default:  nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_detect_sched_if.sv
// Request/detection bus between the serial front-ends and seq_detect_sched.
// Signals:
//   req_valid/req_bit  per-channel pending bit (front-end drives)
//   req_ready          one-hot grant (scheduler drives)
//   ch_clear           per-channel state/counter clear (front-end drives)
//   det_valid/det_ch   registered detection event (scheduler drives)
interface seq_detect_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] req_valid;
    logic [NUM_CH-1:0] req_bit;
    logic [NUM_CH-1:0] req_ready;
    logic [NUM_CH-1:0] ch_clear;
    logic              det_valid;
    logic [CH_W-1:0]   det_ch;

    modport master (
        output req_valid, req_bit, ch_clear,
        input  req_ready, det_valid, det_ch
    );

    modport slave (
        input  req_valid, req_bit, ch_clear,
        output req_ready, det_valid, det_ch
    );
endinterface

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester above the last
// granted index, wrapping from N-1 to 0.
// Ports:
//   clk, reset   clock, synchronous active-high reset (pointer -> N-1)
//   eligible     request vector already masked by the caller
//   advance      move the pointer to grant_idx at this edge
//   grant        one-hot grant (combinational)
//   grant_idx    encoded grant index (combinational)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  eligible,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_r;
    logic [IW:0]   cand_s;
    logic          found_s;

    // Scan ptr+1 .. ptr+N (modulo N) and take the first eligible requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = {1'b0, ptr_r} + (IW+1)'(k);
            if (cand_s >= (IW+1)'(N)) begin
                cand_s = cand_s - (IW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && eligible[cand_s[IW-1:0]]) begin
                found_s   = 1'b1;
                grant_idx = cand_s[IW-1:0];
            end else begin
                found_s   = found_s;
            end
        end
        grant[grant_idx] = found_s;
    end

    // Pointer register; N-1 after reset so that channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= IW'(N - 1);
        end else if (advance) begin
            ptr_r <= grant_idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-multiplexed 1011 detector: one next-state engine shared by NUM_CH
// serial channels, with a per-channel state file and saturating hit counters.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         request/grant/detection interface (slave side)
//   cnt_sel     hit-counter read select
//   cnt_data    combinational read of counter cnt_sel (0 for unused selects)
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    seq_detect_sched_if.slave   bus,
    input  logic [CH_W-1:0]     cnt_sel,
    output logic [CNT_W-1:0]    cnt_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r [NUM_CH];
    logic [CNT_W-1:0]  cnt_r   [NUM_CH];
    logic              det_valid_r;
    logic [CH_W-1:0]   det_ch_r;

    logic [NUM_CH-1:0] eligible_s;
    logic [NUM_CH-1:0] grant_s;
    logic [CH_W-1:0]   gidx_s;
    logic              xfer_s;
    state_t            nxt_state_s;
    logic              hit_s;

    // Cleared channels sit out this cycle; nothing is granted during reset.
    assign eligible_s = bus.req_valid & ~bus.ch_clear & {NUM_CH{~reset}};
    assign xfer_s     = |grant_s;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .eligible  (eligible_s),
        .advance   (xfer_s),
        .grant     (grant_s),
        .grant_idx (gidx_s)
    );

    // Shared engine: next state of the granted channel and its detection flag.
    always_comb begin
        nxt_state_s = next_state(state_r[gidx_s], bus.req_bit[gidx_s]);
        hit_s       = 1'b0;
        if (xfer_s && (nxt_state_s == SEQ_1011)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // State file and counters; a clear overrides any update on that channel.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || bus.ch_clear[i]) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= '0;
            end else if (grant_s[i]) begin
                state_r[i] <= nxt_state_s;
                if (hit_s && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end else begin
                state_r[i] <= state_r[i];
                cnt_r[i]   <= cnt_r[i];
            end
        end
    end

    // Detection event register: one-cycle pulse tagged with the channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_valid_r <= 1'b0;
            det_ch_r    <= '0;
        end else begin
            det_valid_r <= hit_s;
            det_ch_r    <= hit_s ? gidx_s : '0;
        end
    end

    // Counter read port; selects beyond NUM_CH-1 return zero.
    always_comb begin
        cnt_data = '0;
        if ({1'b0, cnt_sel} < (CH_W+1)'(NUM_CH)) begin
            cnt_data = cnt_r[cnt_sel];
        end else begin
            cnt_data = '0;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.det_valid = det_valid_r;
    assign bus.det_ch    = det_ch_r;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched (NUM_CH=4, CNT_W=8).
module tb_seq_detect_sched;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_data;

    seq_detect_sched_if #(.NUM_CH(N)) bus();

    seq_detect_sched #(.NUM_CH(N), .CH_W(2), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cnt_sel  (cnt_sel),
        .cnt_data (cnt_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int det_seen = 0;

    // Reference model: per-channel history of accepted bits, counters, rr pointer.
    int         m_ptr;
    int         m_cnt  [N];
    logic [3:0] m_hist [N];
    int         m_len  [N];
    logic       m_det;
    int         m_det_ch;
    int         last_grant;
    logic [3:0] act_ready;

    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] b;
        logic [3:0] c;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic       dv;
        logic [1:0] dch;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle driven from the negedge and checked against the model.
    task automatic mcycle(input logic rst, input logic [3:0] v, input logic [3:0] b,
                          input logic [3:0] clr, input logic [1:0] sel);
        logic [3:0] elig;
        logic [3:0] exp_rdy;
        int g;
        reset = rst; bus.req_valid = v; bus.req_bit = b; bus.ch_clear = clr; cnt_sel = sel;
        #1;
        g = -1;
        elig = v & ~clr;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && elig[c]) g = c;
            end
        end
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        act_ready = bus.req_ready;
        chk("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
        if (!rst) chk("cnt_data", {24'd0, cnt_data}, m_cnt[sel]);
        m_det = 1'b0;
        m_det_ch = 0;
        if (rst) begin
            m_ptr = N - 1;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_hist[i] = 4'b0000; m_len[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clr[i]) begin
                    m_cnt[i] = 0; m_hist[i] = 4'b0000; m_len[i] = 0;
                end
            end
            if (g >= 0) begin
                m_hist[g] = {m_hist[g][2:0], b[g]};
                if (m_len[g] < 4) m_len[g]++;
                if (m_len[g] == 4 && m_hist[g] == 4'b1011) begin
                    m_det = 1'b1;
                    m_det_ch = g;
                    if (m_cnt[g] < 255) m_cnt[g]++;
                end
                m_ptr = g;
            end
        end
        last_grant = g;
        @(posedge clk);
        @(negedge clk);
        if (bus.det_valid) det_seen++;
        chk("det_valid", {31'd0, bus.det_valid}, {31'd0, m_det});
        if (m_det) chk("det_ch", {30'd0, bus.det_ch}, m_det_ch);
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                                input logic [1:0] sel, input logic [3:0] rdy, input logic dv,
                                input logic [1:0] dch, input logic [7:0] cnt);
        vec_t r;
        r.rst = 1'b0; r.v = v; r.b = b; r.c = c; r.sel = sel;
        r.rdy = rdy; r.dv = dv; r.dch = dch; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        int idx [N];
        int d0;
        logic [3:0] pend;
        logic [3:0] pbit;
        logic [3:0] clr;
        logic [3:0] bv;

        reset = 1'b1; bus.req_valid = '0; bus.req_bit = '0; bus.ch_clear = '0; cnt_sel = '0;
        @(negedge clk);
        mcycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        mcycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0);

        // Table: ch0 1011, ch1 clear after 101, ch0 counter clear, ch2 overlap.
        tbl[0]  = mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
        tbl[1]  = mk(4'b0001, 4'b0000, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
        tbl[2]  = mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 1'b0, 2'd0, 8'd0);
        tbl[3]  = mk(4'b0001, 4'b0001, 4'b0000, 2'd0, 4'b0001, 1'b1, 2'd0, 8'd0);
        tbl[4]  = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 2'd0, 8'd1);
        tbl[5]  = mk(4'b0010, 4'b0010, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd0, 8'd0);
        tbl[6]  = mk(4'b0010, 4'b0000, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd0, 8'd0);
        tbl[7]  = mk(4'b0010, 4'b0010, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd0, 8'd0);
        tbl[8]  = mk(4'b0010, 4'b0010, 4'b0010, 2'd1, 4'b0000, 1'b0, 2'd0, 8'd0);
        tbl[9]  = mk(4'b0010, 4'b0010, 4'b0000, 2'd1, 4'b0010, 1'b0, 2'd0, 8'd0);
        tbl[10] = mk(4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1'b0, 2'd0, 8'd1);
        tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 2'd0, 8'd0);
        tbl[12] = mk(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'b0100, 1'b0, 2'd0, 8'd0);
        tbl[13] = mk(4'b0100, 4'b0000, 4'b0000, 2'd2, 4'b0100, 1'b0, 2'd0, 8'd0);
        tbl[14] = mk(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'b0100, 1'b0, 2'd0, 8'd0);
        tbl[15] = mk(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'b0100, 1'b1, 2'd2, 8'd0);
        tbl[16] = mk(4'b0100, 4'b0000, 4'b0000, 2'd2, 4'b0100, 1'b0, 2'd0, 8'd1);
        tbl[17] = mk(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'b0100, 1'b0, 2'd0, 8'd1);
        tbl[18] = mk(4'b0100, 4'b0100, 4'b0000, 2'd2, 4'b0100, 1'b1, 2'd2, 8'd1);
        tbl[19] = mk(4'b0000, 4'b0000, 4'b0000, 2'd2, 4'b0000, 1'b0, 2'd0, 8'd2);
        for (int r = 0; r < 20; r++) begin
            reset = tbl[r].rst; bus.req_valid = tbl[r].v; bus.req_bit = tbl[r].b;
            bus.ch_clear = tbl[r].c; cnt_sel = tbl[r].sel;
            #1;
            chk($sformatf("tbl%0d_ready", r), {28'd0, bus.req_ready}, {28'd0, tbl[r].rdy});
            chk($sformatf("tbl%0d_cnt", r), {24'd0, cnt_data}, {24'd0, tbl[r].cnt});
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_det", r), {31'd0, bus.det_valid}, {31'd0, tbl[r].dv});
            if (tbl[r].dv) chk($sformatf("tbl%0d_ch", r), {30'd0, bus.det_ch}, {30'd0, tbl[r].dch});
        end

        // All four channels stream 1011 continuously.
        mcycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i < N; i++) idx[i] = 0;
        d0 = det_seen;
        for (int c = 0; c < 16; c++) begin
            pend = '0; bv = '0;
            for (int i = 0; i < N; i++) begin
                pend[i] = (idx[i] < 4);
                bv[i]   = (idx[i] < 4) ? pat[idx[i]] : 1'b0;
            end
            mcycle(1'b0, pend, bv, 4'b0000, 2'(c % 4));
            chk("rr_order", {28'd0, act_ready}, 32'(1 << (c % 4)));
            if (last_grant >= 0) idx[last_grant]++;
        end
        chk("rr_det_count", det_seen - d0, 32'd4);

        // Saturation on ch3.
        d0 = det_seen;
        for (int p = 0; p < 260; p++) begin
            for (int j = 0; j < 4; j++) mcycle(1'b0, 4'b1000, {pat[j], 3'b000}, 4'b0000, 2'd3);
        end
        chk("sat_det_count", det_seen - d0, 32'd260);
        mcycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        chk("sat_cnt", {24'd0, cnt_data}, 32'd255);

        // Reset while ch0 is in 101 with its final 1 pending.
        mcycle(1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0);
        mcycle(1'b0, 4'b0001, 4'b0000, 4'b0000, 2'd0);
        mcycle(1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0);
        d0 = det_seen;
        mcycle(1'b1, 4'b0001, 4'b0001, 4'b0000, 2'd0);
        chk("rst_no_det", det_seen - d0, 32'd0);
        mcycle(1'b0, 4'b0011, 4'b0011, 4'b0000, 2'd0);
        chk("rst_first_grant", {28'd0, act_ready}, 32'd1);
        chk("rst_no_det2", det_seen - d0, 32'd0);

        // Randomised traffic against the model.
        pend = '0; pbit = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    pbit[i] = ($urandom_range(0, 9) < 6);
                end
            end
            clr = '0;
            for (int i = 0; i < N; i++) clr[i] = ($urandom_range(0, 19) == 0);
            mcycle(($urandom_range(0, 99) == 0), pend, pbit, clr, 2'($urandom_range(0, 3)));
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
